// File: rtl/mixer_tdm.sv
// mixer_tdm: time-multiplexed stereo mixer.
//
// One frame of NR_OF_CHANNELS_P signed samples is accepted per in_valid/in_ready
// handshake. Each channel passes through one shared two-stage gain/pan multiplier,
// one channel per clock, and is summed into wide left/right accumulators. The sums
// are saturated, the master gain is applied, the result is saturated again, and it
// is presented on a valid/ready egress that holds until it is accepted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data           NR_OF_CHANNELS_P packed signed samples, channel 0 in the LSBs
//   in_valid/in_ready frame ingress handshake (in_ready only in IDLE)
//   out_left/right    signed mixed samples, stable while out_valid
//   out_clip          a clamp occurred while producing this frame
//   out_valid/ready   frame egress handshake
//   cr_channel_gain   per-channel unsigned gain, Q_BITS_P fractional bits
//   cr_channel_pan    per-channel pan, 0 = full left, 2^PAN_WIDTH_P = full right
//   cr_output_gain    master gain, Q_BITS_P fractional bits
//
// Optional feature, enabled by defining MIXER_TDM_PEAK_METER_EN:
//   peak_clear        zeroes the peak meters (priority over an update)
//   peak_left/right   running max of |out| over accepted output frames

module mixer_tdm #(
    parameter int unsigned AUDIO_WIDTH_P    = 24,
    parameter int unsigned GAIN_WIDTH_P     = 16,
    parameter int unsigned Q_BITS_P         = 12,
    parameter int unsigned PAN_WIDTH_P      = 8,
    parameter int unsigned NR_OF_CHANNELS_P = 4
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [NR_OF_CHANNELS_P-1:0][AUDIO_WIDTH_P-1:0]     in_data,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    output logic signed [AUDIO_WIDTH_P-1:0]                    out_left,
    output logic signed [AUDIO_WIDTH_P-1:0]                    out_right,
    output logic                                               out_clip,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    input  logic [NR_OF_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0]      cr_channel_gain,
    input  logic [NR_OF_CHANNELS_P-1:0][PAN_WIDTH_P:0]         cr_channel_pan,
    input  logic [GAIN_WIDTH_P-1:0]                            cr_output_gain
`ifdef MIXER_TDM_PEAK_METER_EN
   ,input  logic                                               peak_clear,
    output logic [AUDIO_WIDTH_P-2:0]                           peak_left,
    output logic [AUDIO_WIDTH_P-2:0]                           peak_right
`endif
);

    localparam int unsigned IdxW   = (NR_OF_CHANNELS_P > 1) ? $clog2(NR_OF_CHANNELS_P) : 1;
    // sample x zero-extended gain
    localparam int unsigned MulW   = AUDIO_WIDTH_P + GAIN_WIDTH_P + 1;
    // zero-extended pan weight, signed
    localparam int unsigned PanW   = PAN_WIDTH_P + 2;
    localparam int unsigned Prod2W = MulW + PanW;
    localparam int unsigned AccW   = AUDIO_WIDTH_P + GAIN_WIDTH_P + $clog2(NR_OF_CHANNELS_P) + 1;

    localparam logic [IdxW-1:0]        LastIdx = IdxW'(NR_OF_CHANNELS_P - 1);
    localparam logic [PAN_WIDTH_P:0]   PanFull = {1'b1, {PAN_WIDTH_P{1'b0}}};

    localparam logic signed [AccW-1:0] AccMax =
        $signed({{(AccW-AUDIO_WIDTH_P+1){1'b0}}, {(AUDIO_WIDTH_P-1){1'b1}}});
    localparam logic signed [AccW-1:0] AccMin =
        $signed({{(AccW-AUDIO_WIDTH_P+1){1'b1}}, {(AUDIO_WIDTH_P-1){1'b0}}});
    localparam logic signed [MulW-1:0] MstMax =
        $signed({{(MulW-AUDIO_WIDTH_P+1){1'b0}}, {(AUDIO_WIDTH_P-1){1'b1}}});
    localparam logic signed [MulW-1:0] MstMin =
        $signed({{(MulW-AUDIO_WIDTH_P+1){1'b1}}, {(AUDIO_WIDTH_P-1){1'b0}}});

    // Clamp helpers return {clipped, value}.
    function automatic logic [AUDIO_WIDTH_P:0] clamp_acc(input logic signed [AccW-1:0] v);
        if (v > AccMax) begin
            return {1'b1, 1'b0, {(AUDIO_WIDTH_P-1){1'b1}}};
        end else if (v < AccMin) begin
            return {1'b1, 1'b1, {(AUDIO_WIDTH_P-1){1'b0}}};
        end else begin
            return {1'b0, AUDIO_WIDTH_P'(v)};
        end
    endfunction

    function automatic logic [AUDIO_WIDTH_P:0] clamp_mst(input logic signed [MulW-1:0] v);
        if (v > MstMax) begin
            return {1'b1, 1'b0, {(AUDIO_WIDTH_P-1){1'b1}}};
        end else if (v < MstMin) begin
            return {1'b1, 1'b1, {(AUDIO_WIDTH_P-1){1'b0}}};
        end else begin
            return {1'b0, AUDIO_WIDTH_P'(v)};
        end
    endfunction

    typedef enum logic [2:0] {StIdle, StMac, StDrain, StGain, StOut} state_e;

    state_e state_q, state_d;

    logic                  accept;
    logic                  mac_issue;
    logic                  gain_load;
    logic [IdxW-1:0]       idx_q;
    logic                  drain_q;

    // Frame registers: snapshot of samples and config taken at accept.
    logic [NR_OF_CHANNELS_P-1:0][AUDIO_WIDTH_P-1:0] sample_q;
    logic [NR_OF_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0]  gain_q;
    logic [NR_OF_CHANNELS_P-1:0][PAN_WIDTH_P:0]     pan_q;
    logic [GAIN_WIDTH_P-1:0]                        master_q;

    // Multiplier pipeline.
    logic signed [MulW-1:0]   s1_prod;
    logic [PAN_WIDTH_P:0]     pan_clamped;
    logic                     s1_vld_q;
    logic signed [MulW-1:0]   s1_p_q;
    logic [PAN_WIDTH_P:0]     s1_pan_q;
    logic signed [Prod2W-1:0] s2_prod_l;
    logic signed [Prod2W-1:0] s2_prod_r;
    logic                     s2_vld_q;
    logic signed [AccW-1:0]   s2_l_q;
    logic signed [AccW-1:0]   s2_r_q;

    logic signed [AccW-1:0]   acc_l_q;
    logic signed [AccW-1:0]   acc_r_q;

    // Output gain path.
    logic [AUDIO_WIDTH_P:0]         sat1_l;
    logic [AUDIO_WIDTH_P:0]         sat1_r;
    logic signed [MulW-1:0]         mst_prod_l;
    logic signed [MulW-1:0]         mst_prod_r;
    logic [AUDIO_WIDTH_P:0]         sat2_l;
    logic [AUDIO_WIDTH_P:0]         sat2_r;
    logic                           clip_any;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)          state_d = StMac;
            StMac:   if (idx_q == LastIdx)  state_d = StDrain;
            StDrain: if (drain_q)           state_d = StGain;
            StGain:                         state_d = StOut;
            StOut:   if (out_ready)         state_d = StIdle;
            default:                        state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StOut);
        mac_issue = (state_q == StMac);
        gain_load = (state_q == StGain);
    end

    assign accept = in_valid && in_ready;

    // ------------------------------------------------------ sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            if (accept) begin
                idx_q <= '0;
            end else if (mac_issue) begin
                idx_q <= idx_q + 1'b1;
            end
            // Counts the two DRAIN cycles; always enters DRAIN at 0.
            drain_q <= (state_q == StDrain) ? ~drain_q : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            gain_q   <= '0;
            pan_q    <= '0;
            master_q <= '0;
        end else if (accept) begin
            sample_q <= in_data;
            gain_q   <= cr_channel_gain;
            pan_q    <= cr_channel_pan;
            master_q <= cr_output_gain;
        end
    end

    // ------------------------------------------------------ pipeline
    always_comb begin
        s1_prod = MulW'($signed(sample_q[idx_q])) * MulW'($signed({1'b0, gain_q[idx_q]}));
        pan_clamped = (pan_q[idx_q] > PanFull) ? PanFull : pan_q[idx_q];
        s2_prod_l = Prod2W'(s1_p_q) * Prod2W'($signed({1'b0, PanFull - s1_pan_q}));
        s2_prod_r = Prod2W'(s1_p_q) * Prod2W'($signed({1'b0, s1_pan_q}));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_p_q   <= '0;
            s1_pan_q <= '0;
            s2_vld_q <= 1'b0;
            s2_l_q   <= '0;
            s2_r_q   <= '0;
        end else begin
            s1_vld_q <= mac_issue;
            s2_vld_q <= s1_vld_q;
            if (mac_issue) begin
                s1_p_q   <= s1_prod >>> Q_BITS_P;
                s1_pan_q <= pan_clamped;
            end
            if (s1_vld_q) begin
                s2_l_q <= AccW'(s2_prod_l >>> PAN_WIDTH_P);
                s2_r_q <= AccW'(s2_prod_r >>> PAN_WIDTH_P);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_l_q <= '0;
            acc_r_q <= '0;
        end else if (accept) begin
            acc_l_q <= '0;
            acc_r_q <= '0;
        end else if (s2_vld_q) begin
            acc_l_q <= acc_l_q + s2_l_q;
            acc_r_q <= acc_r_q + s2_r_q;
        end
    end

    // ------------------------------------------------------ output gain
    always_comb begin
        sat1_l     = clamp_acc(acc_l_q);
        sat1_r     = clamp_acc(acc_r_q);
        mst_prod_l = MulW'($signed(sat1_l[AUDIO_WIDTH_P-1:0]))
                   * MulW'($signed({1'b0, master_q}));
        mst_prod_r = MulW'($signed(sat1_r[AUDIO_WIDTH_P-1:0]))
                   * MulW'($signed({1'b0, master_q}));
        sat2_l     = clamp_mst(mst_prod_l >>> Q_BITS_P);
        sat2_r     = clamp_mst(mst_prod_r >>> Q_BITS_P);
        clip_any   = sat1_l[AUDIO_WIDTH_P] | sat1_r[AUDIO_WIDTH_P]
                   | sat2_l[AUDIO_WIDTH_P] | sat2_r[AUDIO_WIDTH_P];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_left  <= '0;
            out_right <= '0;
            out_clip  <= 1'b0;
        end else if (accept) begin
            out_clip  <= 1'b0;
        end else if (gain_load) begin
            out_left  <= $signed(sat2_l[AUDIO_WIDTH_P-1:0]);
            out_right <= $signed(sat2_r[AUDIO_WIDTH_P-1:0]);
            out_clip  <= clip_any;
        end
    end

`ifdef MIXER_TDM_PEAK_METER_EN
    localparam int unsigned MagW = AUDIO_WIDTH_P - 1;

    // |v| with the most negative code folded onto the largest positive one.
    function automatic logic [MagW-1:0] mag(input logic signed [AUDIO_WIDTH_P-1:0] v);
        if (v == $signed({1'b1, {MagW{1'b0}}})) begin
            return '1;
        end else if (v < 0) begin
            return MagW'(-v);
        end else begin
            return MagW'(v);
        end
    endfunction

    logic [MagW-1:0] mag_l;
    logic [MagW-1:0] mag_r;

    always_comb begin
        mag_l = mag(out_left);
        mag_r = mag(out_right);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_left  <= '0;
            peak_right <= '0;
        end else if (peak_clear) begin
            peak_left  <= '0;
            peak_right <= '0;
        end else if (out_valid && out_ready) begin
            if (mag_l > peak_left) begin
                peak_left <= mag_l;
            end
            if (mag_r > peak_right) begin
                peak_right <= mag_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mixer_tdm.sv
// Directed bench for mixer_tdm with hand-computed expected values.
module tb_mixer_tdm;

    localparam int unsigned AW = 24;
    localparam int unsigned GW = 16;
    localparam int unsigned QB = 12;
    localparam int unsigned PW = 8;
    localparam int unsigned N  = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [N-1:0][AW-1:0]       in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [AW-1:0]       out_left;
    logic signed [AW-1:0]       out_right;
    logic                       out_clip;
    logic                       out_valid;
    logic                       out_ready;
    logic [N-1:0][GW-1:0]       cr_channel_gain;
    logic [N-1:0][PW:0]         cr_channel_pan;
    logic [GW-1:0]              cr_output_gain;
`ifdef MIXER_TDM_PEAK_METER_EN
    logic                       peak_clear;
    logic [AW-2:0]              peak_left;
    logic [AW-2:0]              peak_right;
`endif

    always #5 clk = ~clk;

    mixer_tdm #(
        .AUDIO_WIDTH_P    (AW),
        .GAIN_WIDTH_P     (GW),
        .Q_BITS_P         (QB),
        .PAN_WIDTH_P      (PW),
        .NR_OF_CHANNELS_P (N)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_left        (out_left),
        .out_right       (out_right),
        .out_clip        (out_clip),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .cr_channel_gain (cr_channel_gain),
        .cr_channel_pan  (cr_channel_pan),
        .cr_output_gain  (cr_output_gain)
`ifdef MIXER_TDM_PEAK_METER_EN
       ,.peak_clear      (peak_clear),
        .peak_left       (peak_left),
        .peak_right      (peak_right)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_cfg();
        in_data         = '0;
        cr_channel_gain = '0;
        cr_channel_pan  = '0;
        cr_output_gain  = GW'(4096);
    endtask

    task automatic set_ch(input int k, input int d, input int g, input int p);
        in_data[k]         = d[AW-1:0];
        cr_channel_gain[k] = g[GW-1:0];
        cr_channel_pan[k]  = p[PW:0];
    endtask

    // Accepts one frame and waits for out_valid. Latency counts the accept edge as
    // cycle 1, so out_valid must be seen on cycle N+4. With out_ready high the
    // task also consumes the output and checks the return to IDLE.
    task automatic do_frame(input string tag, input longint exp_l, input longint exp_r,
                            input longint exp_c);
        int lat;
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/in_ready"}, longint'(in_ready), 1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, lat, N + 4);
        check({tag, "/left"},  longint'(out_left),  exp_l);
        check({tag, "/right"}, longint'(out_right), exp_r);
        check({tag, "/clip"},  longint'(out_clip),  exp_c);
        if (out_ready) begin
            @(posedge clk); #1;
            check({tag, "/valid_drop"}, longint'(out_valid), 0);
        end
    endtask

    initial begin
        bit seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clear_cfg();
`ifdef MIXER_TDM_PEAK_METER_EN
        peak_clear = 1'b0;
`endif
        #2;
        check("rst/in_ready",  longint'(in_ready),  1);
        check("rst/out_valid", longint'(out_valid), 0);
        check("rst/left",      longint'(out_left),  0);
        check("rst/right",     longint'(out_right), 0);
        check("rst/clip",      longint'(out_clip),  0);
`ifdef MIXER_TDM_PEAK_METER_EN
        check("rst/peak_l",    longint'(peak_left), 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single channel full left; other channels carry data but are muted.
        clear_cfg();
        set_ch(0, 1000, 4096, 0);
        set_ch(1, 5555, 0, 0);
        set_ch(2, -777, 0, 256);
        set_ch(3, 12345, 0, 128);
        do_frame("solo_left", 1000, 0, 0);

        // Centre pan splits 50/50.
        clear_cfg();
        set_ch(0, 1000, 4096, 128);
        set_ch(1, 0, 4096, 0);
        set_ch(2, 0, 4096, 0);
        set_ch(3, 0, 4096, 0);
        do_frame("centre", 500, 500, 0);

        // Half gain on a negative sample.
        clear_cfg();
        set_ch(0, -1000, 2048, 0);
        do_frame("half_neg", -500, 0, 0);

        // Four full-scale channels overflow positive.
        clear_cfg();
        for (int k = 0; k < N; k++) set_ch(k, 8388607, 4096, 0);
        do_frame("sat_pos", 8388607, 0, 1);

        // Four negative full-scale channels, full right.
        clear_cfg();
        for (int k = 0; k < N; k++) set_ch(k, -8388608, 4096, 256);
        do_frame("sat_neg", 0, -8388608, 1);

        // Pan beyond full right clamps to full right.
        clear_cfg();
        set_ch(0, 1000, 4096, 300);
        do_frame("pan_clamp", 0, 1000, 0);

        // Master gain 2.0 without and with overflow.
        clear_cfg();
        set_ch(0, 1000, 4096, 0);
        cr_output_gain = GW'(8192);
        do_frame("master_x2", 2000, 0, 0);
        clear_cfg();
        set_ch(0, 8000000, 4096, 0);
        cr_output_gain = GW'(8192);
        do_frame("master_clip", 8388607, 0, 1);

        // Mixed: ch2 p=-200 -> l=-150 r=-50; ch3 p=-3 -> -1.5 floors to -2 each side.
        clear_cfg();
        set_ch(0, 1000, 4096, 0);
        set_ch(1, 2000, 4096, 256);
        set_ch(2, -400, 2048, 64);
        set_ch(3, -3, 4096, 128);
        do_frame("mixed", 848, 1948, 0);

        // Back-pressure: output held while inputs and config move underneath.
        clear_cfg();
        set_ch(0, 1000, 4096, 0);
        out_ready = 1'b0;
        do_frame("stall", 1000, 0, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_ch(0, 3000 + i, 4096 - i, i);
            cr_output_gain = GW'(1000 + i);
            @(posedge clk); #1;
            check("stall/valid",    longint'(out_valid), 1);
            check("stall/left",     longint'(out_left),  1000);
            check("stall/in_ready", longint'(in_ready),  0);
        end
        clear_cfg();
        set_ch(0, 1000, 4096, 0);
        cr_output_gain = GW'(8192);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release/valid",    longint'(out_valid), 0);
        check("release/in_ready", longint'(in_ready),  1);
        do_frame("new_cfg", 2000, 0, 0);

        // Reset during MAC with in_valid held.
        clear_cfg();
        set_ch(0, 1000, 4096, 0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst/in_ready", longint'(in_ready),  1);
        check("midrst/valid",    longint'(out_valid), 0);
        check("midrst/left",     longint'(out_left),  0);
        check("midrst/right",    longint'(out_right), 0);
        check("midrst/clip",     longint'(out_clip),  0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        check("midrst/ready_after", longint'(in_ready), 1);
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst/no_spurious", longint'(seen_valid), 0);
        clear_cfg();
        set_ch(0, -1000, 2048, 0);
        do_frame("post_rst", -500, 0, 0);

`ifdef MIXER_TDM_PEAK_METER_EN
        peak_clear = 1'b1;
        @(posedge clk); #1;
        peak_clear = 1'b0;
        check("peak/cleared0", longint'(peak_left), 0);
        clear_cfg();
        set_ch(0, 300, 4096, 0);
        do_frame("peak_f1", 300, 0, 0);
        check("peak/after300", longint'(peak_left), 300);
        set_ch(0, -700, 4096, 0);
        do_frame("peak_f2", -700, 0, 0);
        check("peak/after700", longint'(peak_left), 700);
        set_ch(0, 200, 4096, 0);
        do_frame("peak_f3", 200, 0, 0);
        check("peak/after200", longint'(peak_left),  700);
        check("peak/right",    longint'(peak_right), 0);
        clear_cfg();
        for (int k = 0; k < N; k++) set_ch(k, -8388608, 4096, 256);
        do_frame("peak_min", 0, -8388608, 1);
        check("peak/right_min", longint'(peak_right), 8388607);
        peak_clear = 1'b1;
        @(posedge clk); #1;
        peak_clear = 1'b0;
        check("peak/cleared_l", longint'(peak_left),  0);
        check("peak/cleared_r", longint'(peak_right), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
